// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs (decode/execute/memory) and stall/flush/counter outputs of pipeline_ctrl
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic [1:0]       rs_used_D;
    logic [4:0]       rd_X;
    logic             mem_read_X;
    logic             pc_src_X;
    logic             dmem_req_M;
    logic             dmem_ready_M;
    logic             stall_F;
    logic             stall_D;
    logic             stall_X;
    logic             stall_M;
    logic             flush_D;
    logic             flush_X;
    logic             flush_W;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output rs1_D, rs2_D, rs_used_D, rd_X, mem_read_X, pc_src_X, dmem_req_M, dmem_ready_M,
        input  stall_F, stall_D, stall_X, stall_M, flush_D, flush_X, flush_W, mem_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  rs1_D, rs2_D, rs_used_D, rd_X, mem_read_X, pc_src_X, dmem_req_M, dmem_ready_M,
        output stall_F, stall_D, stall_X, stall_M, flush_D, flush_X, flush_W, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush scheduler (load-use, taken branch, memory wait with timeout) with saturating counters
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst_n,
    pipeline_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
    state_t            state, state_nx;
    logic [WC_W-1:0]   wait_cnt, wait_cnt_nx;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              mem_wait, hold, br, lu, load_use;
    assign mem_wait = bus.dmem_req_M & ~bus.dmem_ready_M;
    assign load_use = bus.mem_read_X & (bus.rd_X != 5'd0) &
                      ((bus.rs_used_D[0] & (bus.rs1_D == bus.rd_X)) |
                       (bus.rs_used_D[1] & (bus.rs2_D == bus.rd_X)));
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        if (state == RUN && mem_wait) begin
            state_nx    = MEM_WAIT;
            wait_cnt_nx = WC_W'(1);
        end else if (state == MEM_WAIT) begin
            if (bus.dmem_ready_M) begin
                state_nx    = RUN;
                wait_cnt_nx = '0;
            end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                state_nx = ERR;
            end else begin
                wait_cnt_nx = wait_cnt + WC_W'(1);
            end
        end
    end
    assign hold = rst_n & ((state == ERR) | ((state == RUN) & mem_wait) |
                           ((state == MEM_WAIT) & ~bus.dmem_ready_M));
    assign br   = rst_n & ~hold & bus.pc_src_X;
    assign lu   = rst_n & ~hold & ~bus.pc_src_X & load_use;
    assign bus.stall_F   = hold | lu;
    assign bus.stall_D   = hold | lu;
    assign bus.stall_X   = hold;
    assign bus.stall_M   = hold;
    assign bus.flush_D   = br;
    assign bus.flush_X   = br | lu;
    assign bus.flush_W   = hold;
    assign bus.mem_err   = state == ERR;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (bus.stall_F && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (br && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule
